// File: rtl/bram_stream_reader.sv
// Block-RAM stream source: reads len words from a synchronous BRAM and presents them as a valid/ready stream.
// Optional wrap-around looping is compiled in with `define BRAM_READER_LOOP_EN.
`timescale 1ns/1ps
module bram_stream_reader #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 100,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   len,
    input  logic              loop_en,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);
    // Stream handshake: a word moves when out_valid & out_ready at a rising edge;
    // out_valid never drops and out_data never changes while out_ready is low.

    localparam int FIFO_DEPTH = RD_LAT + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
    localparam int SUM_W      = CNT_W + 2;
    localparam int LEN_W      = ADDR_W + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [LEN_W-1:0]   len_q, issue_cnt, len_clamped;
    logic [RD_LAT-1:0]  pipe;
    logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [CNT_W-1:0]   fifo_cnt;
    logic [CNT_W:0]     inflight;
    logic               push, pop, credit_ok, issue, last_issue, wrap;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign len_clamped = (len > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len;

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) begin
            inflight = inflight + (CNT_W + 1)'(pipe[i]);
        end
    end

    assign push      = pipe[RD_LAT-1];
    assign out_valid = (fifo_cnt != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr] : '0;
    assign pop       = out_valid & out_ready;

    // Reads already issued plus words held must fit the FIFO, counting this cycle's pop as freed space.
    assign credit_ok  = (SUM_W'(fifo_cnt) + SUM_W'(inflight)) < (SUM_W'(FIFO_DEPTH) + SUM_W'(pop));
    assign issue      = (state == RUN) && (issue_cnt < len_q) && credit_ok;
    assign last_issue = issue && (issue_cnt == len_q - 1'b1);

`ifdef BRAM_READER_LOOP_EN
    assign wrap = last_issue & loop_en;
`else
    logic unused_loop_en;
    assign unused_loop_en = loop_en;
    assign wrap           = 1'b0;
`endif

    assign mem_en    = issue;
    assign mem_addr  = issue_cnt[ADDR_W-1:0];
    assign busy      = (state != IDLE);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nxt = (len_clamped == '0) ? DRAIN : RUN;
            end
            RUN: begin
                if (last_issue && !wrap) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (fifo_cnt == '0 && inflight == '0) begin
                    state_nxt = IDLE;
                    done      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            len_q     <= '0;
            issue_cnt <= '0;
            pipe      <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
        end else begin
            if (state == IDLE && start) begin
                len_q     <= len_clamped;
                issue_cnt <= '0;
            end
            // The counter returns to zero after the final read so the next pass (or wrap) starts at address 0.
            if (issue) issue_cnt <= last_issue ? '0 : issue_cnt + 1'b1;
            pipe[0] <= issue;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)  rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop)      fifo_cnt <= fifo_cnt + 1'b1;
            else if (!push && pop) fifo_cnt <= fifo_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= mem_dout;
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: one instance at RD_LAT=1 and one at RD_LAT=2 share stimulus,
// each fed by its own BRAM model holding addr^8'h5A.
`timescale 1ns/1ps
module tb_bram_stream_reader;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 100;
  localparam int ADDR_W = 7;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic              start = 1'b0;
  logic              loop_en = 1'b0;
  logic              out_ready = 1'b1;
  logic              rand_ready = 1'b0;
  logic [ADDR_W:0]   len = '0;

  logic              mem_en_a, out_valid_a, busy_a, done_a;
  logic [ADDR_W-1:0] mem_addr_a;
  logic [DATA_W-1:0] mem_dout_a = '0, out_data_a;
  logic [1:0]        dbg_a;
  logic              mem_en_b, out_valid_b, busy_b, done_b;
  logic [ADDR_W-1:0] mem_addr_b;
  logic [DATA_W-1:0] mem_dout_b = '0, stage_b = '0, out_data_b;
  logic [1:0]        dbg_b;

  bram_stream_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(1)) u_dut_a (
    .clk(clk), .rst(rst), .start(start), .len(len), .loop_en(loop_en),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_dout(mem_dout_a),
    .out_valid(out_valid_a), .out_data(out_data_a), .out_ready(out_ready),
    .busy(busy_a), .done(done_a), .dbg_state(dbg_a));

  bram_stream_reader #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .RD_LAT(2)) u_dut_b (
    .clk(clk), .rst(rst), .start(start), .len(len), .loop_en(loop_en),
    .mem_en(mem_en_b), .mem_addr(mem_addr_b), .mem_dout(mem_dout_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .busy(busy_b), .done(done_b), .dbg_state(dbg_b));

  // BRAM models
  always @(posedge clk) if (mem_en_a) mem_dout_a <= {1'b0, mem_addr_a} ^ 8'h5A;
  always @(posedge clk) begin
    if (mem_en_b) stage_b <= {1'b0, mem_addr_b} ^ 8'h5A;
    mem_dout_b <= stage_b;
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [DATA_W-1:0] exp_q0[$];
  logic [DATA_W-1:0] exp_q1[$];
  int pass_len;
  int words[2], dones[2], first_v[2], last_v[2], done_cyc[2];
  int busy_first[2], busy_cnt[2], en_cnt[2], max_addr[2], outstanding[2], max_out[2];
  logic prev_stall[2];
  logic [DATA_W-1:0] prev_data[2];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic clear_stats();
    exp_q0.delete();
    exp_q1.delete();
    for (int d = 0; d < 2; d++) begin
      words[d] = 0; dones[d] = 0; first_v[d] = -1; last_v[d] = -1; done_cyc[d] = -1;
      busy_first[d] = -1; busy_cnt[d] = 0; en_cnt[d] = 0; max_addr[d] = -1;
      outstanding[d] = 0; max_out[d] = 0; prev_stall[d] = 1'b0; prev_data[d] = '0;
    end
  endtask

  task automatic mon(input int d, input logic v, input logic [DATA_W-1:0] data, input logic en,
                     input logic [ADDR_W-1:0] addr, input logic bsy, input logic dn);
    logic [DATA_W-1:0] exp;
    if (prev_stall[d]) check_eq("stall_hold", {23'b0, v, data}, {23'b0, 1'b1, prev_data[d]});
    prev_stall[d] = v && !out_ready;
    prev_data[d] = data;
    if (en) begin
      en_cnt[d]++;
      outstanding[d]++;
      if (int'(addr) > max_addr[d]) max_addr[d] = int'(addr);
    end
    if (bsy) begin
      if (busy_first[d] < 0) busy_first[d] = cyc;
      busy_cnt[d]++;
    end
    if (dn) begin
      dones[d]++;
      done_cyc[d] = cyc;
    end
    if (v) begin
      if (first_v[d] < 0) first_v[d] = cyc;
      last_v[d] = cyc;
    end
    if (v && out_ready) begin
      words[d]++;
      outstanding[d]--;
      if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
        check_eq("extra_word", words[d], pass_len);
      end else begin
        exp = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check_eq((d == 0) ? "data_a" : "data_b", data, exp);
      end
    end
    if (outstanding[d] > max_out[d]) max_out[d] = outstanding[d];
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon(0, out_valid_a, out_data_a, mem_en_a, mem_addr_a, busy_a, done_a);
      mon(1, out_valid_b, out_data_b, mem_en_b, mem_addr_b, busy_b, done_b);
    end
  end

  // driver tasks
  task automatic start_pass(input int l, output int base);
    @(posedge clk);
    #1;
    start = 1'b1;
    len = (ADDR_W+1)'(l);
    @(posedge clk);
    #1;
    base = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int inj);
    for (int i = 1; i <= budget; i++) begin
      if (dones[0] >= 1 && dones[1] >= 1) break;
      @(posedge clk);
      #1;
      start = (i == inj);
      if (i == inj) len = 8'd3;
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic run_pass(input int l, input int e, input int inj, output int base);
    clear_stats();
    pass_len = e;
    for (int i = 0; i < e; i++) begin
      exp_q0.push_back(DATA_W'(i) ^ 8'h5A);
      exp_q1.push_back(DATA_W'(i) ^ 8'h5A);
    end
    start_pass(l, base);
    wait_done(3000, inj);
    check_eq("words_a", words[0], e);
    check_eq("words_b", words[1], e);
    check_eq("done_count_a", dones[0], 1);
    check_eq("done_count_b", dones[1], 1);
    check_eq("queue_left_a", exp_q0.size(), 0);
    check_eq("queue_left_b", exp_q1.size(), 0);
  endtask

  function automatic logic [31:0] outs_a();
    return {11'b0, dbg_a, mem_en_a, mem_addr_a, out_valid_a, out_data_a, busy_a, done_a};
  endfunction
  function automatic logic [31:0] outs_b();
    return {11'b0, dbg_b, mem_en_b, mem_addr_b, out_valid_b, out_data_b, busy_b, done_b};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    clear_stats();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_outputs_a", outs_a(), 0);
    check_eq("reset_outputs_b", outs_b(), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // full-rate pass with reference timing
    run_pass(100, 100, 0, base);
    check_eq("busy_first", busy_first[0] - base, 0);
    check_eq("busy_cycles", busy_cnt[0], 103);
    check_eq("first_valid_a", first_v[0] - base, 2);
    check_eq("last_valid_a", last_v[0] - base, 101);
    check_eq("done_cycle_a", done_cyc[0] - base, 102);
    check_eq("mem_en_count_a", en_cnt[0], 100);
    check_eq("first_valid_b", first_v[1] - base, 3);
    check_eq("throughput_b", last_v[1] - first_v[1], 99);

    // random backpressure
    rand_ready = 1'b1;
    run_pass(37, 37, 0, base);
    check_eq("fifo_bound_a", max_out[0] <= 3, 1);
    check_eq("fifo_bound_b", max_out[1] <= 4, 1);
    check_eq("mem_en_count_b", en_cnt[1], 37);
    rand_ready = 1'b0;

    // degenerate lengths
    run_pass(0, 0, 0, base);
    check_eq("len0_mem_en_a", en_cnt[0], 0);
    check_eq("len0_mem_en_b", en_cnt[1], 0);
    check_eq("len0_done_soon", (done_cyc[0] >= base) && (done_cyc[0] - base <= 2), 1);
    run_pass(150, 100, 0, base);
    check_eq("clamp_mem_en_a", en_cnt[0], 100);
    check_eq("clamp_max_addr_a", max_addr[0], 99);
    check_eq("clamp_mem_en_b", en_cnt[1], 100);

    // start while busy is ignored
    run_pass(50, 50, 10, base);

    // reset mid-pass
    clear_stats();
    pass_len = 60;
    for (int i = 0; i < 60; i++) begin
      exp_q0.push_back(DATA_W'(i) ^ 8'h5A);
      exp_q1.push_back(DATA_W'(i) ^ 8'h5A);
    end
    start_pass(60, base);
    for (int i = 0; i < 500; i++) begin
      if (words[0] >= 20) break;
      @(posedge clk);
      #1;
    end
    check_eq("words_before_reset", words[0] >= 20, 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("midreset_outputs_a", outs_a(), 0);
    check_eq("midreset_outputs_b", outs_b(), 0);
    check_eq("midreset_no_done", dones[0] + dones[1], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    run_pass(5, 5, 0, base);

`ifdef BRAM_READER_LOOP_EN
    clear_stats();
    pass_len = 1000;
    for (int i = 0; i < 200; i++) begin
      exp_q0.push_back(DATA_W'(i % 4) ^ 8'h5A);
      exp_q1.push_back(DATA_W'(i % 4) ^ 8'h5A);
    end
    loop_en = 1'b1;
    start_pass(4, base);
    for (int i = 0; i < 200; i++) begin
      if (words[0] >= 14 && words[1] >= 14) break;
      @(posedge clk);
      #1;
    end
    check_eq("loop_no_done", dones[0] + dones[1], 0);
    check_eq("loop_progress", (words[0] >= 14) && (words[1] >= 14), 1);
    loop_en = 1'b0;
    wait_done(200, 0);
    check_eq("loop_done_a", dones[0], 1);
    check_eq("loop_done_b", dones[1], 1);
    check_eq("loop_whole_pass_a", words[0] % 4, 0);
    check_eq("loop_whole_pass_b", words[1] % 4, 0);
    check_eq("loop_no_gap_a", last_v[0] - first_v[0] + 1, words[0]);
    check_eq("loop_no_gap_b", last_v[1] - first_v[1] + 1, words[1]);
    check_eq("loop_mem_en_a", en_cnt[0], words[0]);
`else
    loop_en = 1'b1;
    run_pass(4, 4, 0, base);
    loop_en = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
